// File: rtl/add_reservation_station.sv
// Two-entry Tomasulo reservation station (ADD1/ADD2) sharing one ADD/SUB unit.
// Pending operands are resolved by snooping the CDB, including this station's own broadcasts.
module add_reservation_station #(
   parameter int                DATA_W      = 16,
   parameter int                ADD_LATENCY = 2,
   parameter logic [1:0]        TAG_FREE    = 2'd0,
   parameter logic [1:0]        TAG_ADD1    = 2'd1,
   parameter logic [1:0]        TAG_ADD2    = 2'd2,
   parameter logic [DATA_W-1:0] V_NONE      = 16'hFFF0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Issue_valid,
   input  logic              Issue_op,
   input  logic [2:0]        Issue_rd,
   input  logic [1:0]        Src_Qj,
   input  logic [1:0]        Src_Qk,
   input  logic [DATA_W-1:0] Src_Vj,
   input  logic [DATA_W-1:0] Src_Vk,
   output logic              Issue_ready,
   output logic              R_enable_ADD1,
   output logic [2:0]        R_target_ADD1,
   output logic              R_enable_ADD2,
   output logic [2:0]        R_target_ADD2,
   input  logic              Cdb_valid,
   input  logic [3:0]        Cdb_tag,
   input  logic [DATA_W-1:0] Cdb_data,
   output logic              Cdb_req,
   output logic [3:0]        Cdb_req_tag,
   output logic [DATA_W-1:0] Cdb_req_data,
   input  logic              Cdb_grant
);
   typedef enum logic [2:0] {S_FREE, S_WAIT, S_READY, S_EXEC, S_DONE} state_t;
   localparam int CNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

   state_t            state [2];
   state_t            state_next [2];
   logic              op [2];
   logic [DATA_W-1:0] vj [2];
   logic [DATA_W-1:0] vk [2];
   logic [1:0]        qj [2];
   logic [1:0]        qk [2];
   logic              older1;     // entry 1 was issued before entry 0
   logic              exec_idx;   // entry owning the adder (EXEC/DONE)
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] result;

   logic [1:0] free, rdy, busy_e, hit_j, hit_k;
   logic       accept, alloc, busy, start, start_idx;
   logic       src_j_ok, src_k_ok;

   // Tag 0 is never a producer, so it can never match.
   function automatic logic snoop(input logic v, input logic [3:0] t, input logic [1:0] q);
      return v && (q != TAG_FREE) && (t == {2'b00, q});
   endfunction

   for (genvar i = 0; i < 2; i++) begin : g_flags
      assign free[i]   = (state[i] == S_FREE);
      assign rdy[i]    = (state[i] == S_READY);
      assign busy_e[i] = (state[i] == S_EXEC) || (state[i] == S_DONE);
      assign hit_j[i]  = snoop(Cdb_valid, Cdb_tag, qj[i]);
      assign hit_k[i]  = snoop(Cdb_valid, Cdb_tag, qk[i]);
   end

   assign Issue_ready = |free;
   assign accept      = Issue_valid && Issue_ready;
   assign alloc       = !free[0];
   assign busy        = |busy_e;
   assign start       = !busy && (|rdy);
   assign start_idx   = (rdy[0] && rdy[1]) ? older1 : rdy[1];
   assign src_j_ok    = (Src_Qj == TAG_FREE) || snoop(Cdb_valid, Cdb_tag, Src_Qj);
   assign src_k_ok    = (Src_Qk == TAG_FREE) || snoop(Cdb_valid, Cdb_tag, Src_Qk);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 2; i++) state[i] <= S_FREE;
      end else begin
         for (int i = 0; i < 2; i++) state[i] <= state_next[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_next[i] = state[i];
         case (state[i])
            S_FREE:  if (accept && alloc == 1'(i))
                        state_next[i] = (src_j_ok && src_k_ok) ? S_READY : S_WAIT;
            S_WAIT:  if ((qj[i] == TAG_FREE || hit_j[i]) && (qk[i] == TAG_FREE || hit_k[i]))
                        state_next[i] = S_READY;
            S_READY: if (start && start_idx == 1'(i)) state_next[i] = S_EXEC;
            S_EXEC:  if (cnt == '0) state_next[i] = S_DONE;
            S_DONE:  if (Cdb_grant) state_next[i] = S_FREE;
            default: state_next[i] = S_FREE;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 2; i++) begin
            op[i] <= 1'b0;
            vj[i] <= V_NONE;
            vk[i] <= V_NONE;
            qj[i] <= TAG_FREE;
            qk[i] <= TAG_FREE;
         end
         older1   <= 1'b0;
         exec_idx <= 1'b0;
         cnt      <= '0;
         result   <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (free[i] && accept && alloc == 1'(i)) begin
               op[i] <= Issue_op;
               vj[i] <= (Src_Qj == TAG_FREE) ? Src_Vj : (src_j_ok ? Cdb_data : V_NONE);
               vk[i] <= (Src_Qk == TAG_FREE) ? Src_Vk : (src_k_ok ? Cdb_data : V_NONE);
               qj[i] <= src_j_ok ? TAG_FREE : Src_Qj;
               qk[i] <= src_k_ok ? TAG_FREE : Src_Qk;
            end else if (state[i] == S_WAIT) begin
               if (hit_j[i]) begin
                  vj[i] <= Cdb_data;
                  qj[i] <= TAG_FREE;
               end
               if (hit_k[i]) begin
                  vk[i] <= Cdb_data;
                  qk[i] <= TAG_FREE;
               end
            end else if (state[i] == S_DONE && Cdb_grant) begin
               op[i] <= 1'b0;
               vj[i] <= V_NONE;
               vk[i] <= V_NONE;
               qj[i] <= TAG_FREE;
               qk[i] <= TAG_FREE;
            end
         end
         // A new entry is younger than whichever entry is still occupied.
         if (accept) older1 <= !alloc && !free[1];
         if (start) begin
            exec_idx <= start_idx;
            cnt      <= CNT_W'(ADD_LATENCY - 1);
         end else if (state[exec_idx] == S_EXEC) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else result <= op[exec_idx] ? (vj[exec_idx] - vk[exec_idx])
                                        : (vj[exec_idx] + vk[exec_idx]);
         end
      end
   end

   always_comb begin
      R_enable_ADD1 = accept && !alloc;
      R_enable_ADD2 = accept && alloc;
      R_target_ADD1 = R_enable_ADD1 ? Issue_rd : 3'd0;
      R_target_ADD2 = R_enable_ADD2 ? Issue_rd : 3'd0;
      Cdb_req       = (state[exec_idx] == S_DONE);
      Cdb_req_tag   = Cdb_req ? {2'b00, (exec_idx ? TAG_ADD2 : TAG_ADD1)} : 4'd0;
      Cdb_req_data  = Cdb_req ? result : '0;
   end
endmodule
